sample_avg: RTL

Downstream consumer of the 4-bit signed sample stream produced by the delay stage. Maintains a sliding window of the last DEPTH accepted samples and outputs their running sum and floor average, registered, with a valid pulse per new result. Sits between the delay stage output and any display or threshold logic that needs a smoothed value.

---
 rtl/sample_avg.sv | 57 +++++
 1 files changed

// File: rtl/sample_avg.sv
// sample_avg: sliding-window running sum and floor average of the last DEPTH accepted signed samples.
module sample_avg #(
  parameter int W     = 4,
  parameter int DEPTH = 4,
  parameter int LOG2D = 2
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [W-1:0]         din,
  input  logic                 din_valid,
  input  logic                 flush,
  output logic [W+LOG2D-1:0]   sum,
  output logic [W-1:0]         avg,
  output logic                 avg_valid,
  output logic [LOG2D:0]       fill
);
  localparam int S = W + LOG2D;
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} state_t;
  state_t state, state_next;
  logic [W-1:0] win [DEPTH];
  logic [S-1:0] sum_next;
  logic [LOG2D:0] fill_next;
  logic pulse_next, accept;
  assign accept = din_valid & ~flush;
  assign avg = sum[S-1:LOG2D];
  always_ff @(posedge clk or posedge clear)
    if (clear) begin
      state     <= EMPTY;
      fill      <= '0;
      sum       <= '0;
      avg_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else begin
      state     <= state_next;
      fill      <= fill_next;
      sum       <= sum_next;
      avg_valid <= pulse_next;
      if (flush)
        for (int i = 0; i < DEPTH; i++) win[i] <= '0;
      else if (accept) begin
        win[0] <= din;
        for (int i = 1; i < DEPTH; i++) win[i] <= win[i-1];
      end
    end
  always_comb begin
    state_next = flush ? EMPTY :
                 !accept ? state :
                 (state == FULL || fill == (LOG2D+1)'(DEPTH-1)) ? FULL : FILLING;
    fill_next  = flush ? '0 : (accept && state != FULL) ? fill + 1'b1 : fill;
  end
  // Empty slots hold zero, so subtracting the outgoing entry is correct during fill too.
  always_comb begin
    sum_next   = flush ? '0 :
                 accept ? sum + {{LOG2D{din[W-1]}}, din} - {{LOG2D{win[DEPTH-1][W-1]}}, win[DEPTH-1]} : sum;
    pulse_next = accept && state_next == FULL;
  end
endmodule
